// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive bridge.
// UART_RX_PARITY_EN adds the even-parity state.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    function automatic int bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers for full/empty.
// Head data reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full push may proceed.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_bridge.sv
// 8N1 UART receiver feeding a byte FIFO with valid/ready output.
// Define UART_RX_PARITY_EN for an even-parity bit before stop.
module uart_rx_bridge
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam int BIT_CYC = bit_cyc(CLK_HZ, BAUD);
    localparam int HALF    = BIT_CYC / 2;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    state_t      state_q, state_d;
    logic        sync1_q, rxs_q, rxs_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        push, pop, full, empty;
    logic        fall, tick_half, tick_bit;

    assign fall      = rxs_prev_q && !rxs_q;
    assign tick_half = cnt_q == HALF_END;
    assign tick_bit  = cnt_q == BIT_END;

    assign valid     = !empty;
    assign pop       = valid && ready;
    assign overrun_d = push && full && !pop;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rx;
            rxs_q        <= sync1_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (fall) state_d = START;
            START:     if (tick_half) state_d = rxs_q ? IDLE : DATA;
            DATA: begin
                if (tick_bit && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (tick_bit) state_d = STOP;
`endif
            STOP:      if (tick_bit) state_d = rxs_q ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        push         = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            START: if (tick_half) cnt_d = '0;
            DATA: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_bit) begin
                    cnt_d = '0;
                    par_d = rxs_q;
                end
            end
`endif
            STOP: begin
                if (tick_bit) begin
                    cnt_d       = '0;
                    frame_err_d = !rxs_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = (^shift_q) != par_q;
                    push         = rxs_q && !parity_err_d;
`else
                    push         = rxs_q;
`endif
                end
            end
            default: cnt_d = '0;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .push       (push),
        .wdata      (shift_q),
        .full       (full),
        .pop        (pop),
        .rdata      (data),
        .empty      (empty)
    );

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Scoreboard bench for uart_rx_bridge at 100 MHz / 115200 baud.
// Stimulus queues expected bytes; a negedge monitor pops and compares.
module tb_uart_rx_bridge;
    import uart_rx_pkg::*;

    localparam int CLK_HZ = 100000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 4;
    localparam int BITC   = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA  = 1;
`else
    localparam int EXTRA  = 0;
`endif
    // rx drive -> 2 sync flops + edge detect, half bit, 8 data bits, stop sample
    localparam int LAT    = 8249 + EXTRA * BITC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, parity_err;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int pops = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int first_valid = -1;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_bridge #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (valid && first_valid < 0) first_valid = cyc;
            if (valid && ready) begin
                pops++;
                if (exp_q.size() == 0)
                    check("unexpected_byte", int'(data), -1);
                else
                    check("byte", int'(data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cycles(BITC);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            cycles(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        cycles(2);
    endtask

    int p0, fe0, ov0, pe0, t0;

    task automatic snap();
        p0  = pops;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
    endtask

    initial begin
        cycles(5);
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_flags", int'({frame_err, overrun, parity_err}), 0);
        rst_n = 1'b1;
        cycles(5);
        check("post_rst_state", int'(dut.state_q), int'(IDLE));

        // single 0xA5 frame with latency check
        ready = 1'b1;
        snap();
        first_valid = -1;
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_drain("a5_drain");
        check("a5_latency", first_valid - t0, LAT);
        check("a5_pops", pops - p0, 1);
        check("a5_flags", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0, 0);

        // short low glitch
        snap();
        rx = 1'b0;
        cycles(300);
        rx = 1'b1;
        cycles(1000);
        check("glitch_pops", pops - p0, 0);
        check("glitch_flags", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0, 0);
        check("glitch_state", int'(dut.state_q), int'(IDLE));

        // bad stop bit, then a long break
        snap();
        send_frame(8'h3C, 1'b0);
        cycles(5000);
        rx = 1'b1;
        cycles(2 * BITC);
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_pops", pops - p0, 0);
        check("ferr_other", ov_cnt - ov0 + pe_cnt - pe0, 0);
        check("ferr_state", int'(dut.state_q), int'(IDLE));

`ifndef UART_RX_PARITY_EN
        // fill the FIFO with ready low, fifth byte overruns
        ready = 1'b0;
        snap();
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) exp_q.push_back(8'(v));
            send_frame(8'(v), 1'b1);
        end
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_hold_valid", int'(valid), 1);
        check("ovr_hold_data", int'(data), 8'h01);
        check("ovr_no_pop", pops - p0, 0);
        ready = 1'b1;
        wait_drain("ovr_drain");
        check("ovr_pops", pops - p0, 4);
        check("ovr_empty", int'(valid), 0);
`endif

        // reset in the middle of the 4th data bit
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        cycles(BITC / 2);
        rst_n = 1'b0;
        cycles(10);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_state", int'(dut.state_q), int'(IDLE));
        rst_n = 1'b1;
        cycles(2 * BITC);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_drain("rst_drain");
        check("rst_pops", pops - p0, 1);
        check("rst_flags", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0, 0);

`ifdef UART_RX_PARITY_EN
        snap();
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        wait_drain("par_ok_drain");
        check("par_ok_pops", pops - p0, 1);
        check("par_ok_perr", pe_cnt - pe0, 0);
        snap();
        send_frame_par(8'h07, 1'b0);
        cycles(BITC);
        check("par_bad_perr", pe_cnt - pe0, 1);
        check("par_bad_pops", pops - p0, 0);
        check("par_bad_valid", int'(valid), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
